reg_file_wb: RTL

// - Register file plus writeback-select stage of the single-cycle MIPS datapath; directly downstream of the

---
 rtl/mips_pkg.sv | 19 +
 rtl/reg_file_wb_if.sv | 55 +++++
 rtl/wb_select.sv | 42 ++++
 rtl/reg_file_wb.sv | 85 ++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants and types for the single-cycle MIPS
//                datapath (register file / writeback select slice).
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int LINK_REG = 31;
    localparam int REG_ZERO = 0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/reg_file_wb_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_wb_if
//  Description : Bus bundle between the controller/datapath side (master)
//                and the register file + writeback stage (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_wb_if #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int CNT_W  = 32
);
    // Instruction fields
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    // Controller outputs
    logic              RegDst;
    logic              RegJal;
    logic              DataJal;
    logic              RegWrite;
    logic              MemToReg;
    // Write data sources
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] pc_plus4;
    // Read ports
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    // Writeback observation
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  commit_cnt;

    modport master (
        output rs_addr, rt_addr, rd_addr,
        output RegDst, RegJal, DataJal, RegWrite, MemToReg,
        output alu_result, mem_rdata, pc_plus4, dbg_addr,
        input  rs_data, rt_data, dbg_data,
        input  wb_en, wb_addr, wb_data, commit_cnt
    );

    modport slave (
        input  rs_addr, rt_addr, rd_addr,
        input  RegDst, RegJal, DataJal, RegWrite, MemToReg,
        input  alu_result, mem_rdata, pc_plus4, dbg_addr,
        output rs_data, rt_data, dbg_data,
        output wb_en, wb_addr, wb_data, commit_cnt
    );

endinterface : reg_file_wb_if
`default_nettype wire

// File: rtl/wb_select.sv
`default_nettype none
// ============================================================================
//  Module      : wb_select
//  Description : Combinational writeback select: destination index, write
//                data and write enable from the controller signals.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_select #(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int LINK_REG = mips_pkg::LINK_REG
) (
    input  wire logic [ADDR_W-1:0] i_rt_addr,
    input  wire logic [ADDR_W-1:0] i_rd_addr,
    input  wire logic              i_reg_dst,
    input  wire logic              i_reg_jal,
    input  wire logic              i_data_jal,
    input  wire logic              i_reg_write,
    input  wire logic              i_mem_to_reg,
    input  wire logic [DATA_W-1:0] i_alu_result,
    input  wire logic [DATA_W-1:0] i_mem_rdata,
    input  wire logic [DATA_W-1:0] i_pc_plus4,
    output logic                   o_wb_en,
    output logic [ADDR_W-1:0]      o_wb_addr,
    output logic [DATA_W-1:0]      o_wb_data
);

    localparam logic [ADDR_W-1:0] c_link_idx = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] c_zero_idx = ADDR_W'(mips_pkg::REG_ZERO);

    // jal overrides both the destination and the data choice; note that
    // MemToReg=1 picks the ALU result (its polarity is inverted vs. textbook)
    always_comb begin
        o_wb_addr = i_reg_jal  ? c_link_idx
                  : (i_reg_dst ? i_rd_addr : i_rt_addr);
        o_wb_data = i_data_jal ? i_pc_plus4
                  : (i_mem_to_reg ? i_alu_result : i_mem_rdata);
        o_wb_en   = i_reg_write && (o_wb_addr != c_zero_idx);
    end

endmodule : wb_select
`default_nettype wire

// File: rtl/reg_file_wb.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_wb
//  Description : MIPS register file with writeback select, two async read
//                ports, a debug read port and a commit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_wb #(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::ADDR_W,
    parameter int NUM_REGS = 32,
    parameter int LINK_REG = mips_pkg::LINK_REG,
    parameter int CNT_W    = 32
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    reg_file_wb_if.slave  bus
);

    localparam logic [ADDR_W-1:0] c_zero_idx = ADDR_W'(mips_pkg::REG_ZERO);

    logic                   w_wb_en;
    logic [ADDR_W-1:0]      w_wb_addr;
    logic [DATA_W-1:0]      w_wb_data;
    logic [DATA_W-1:0]      r_regs [NUM_REGS];
    logic [CNT_W-1:0]       r_commit_cnt;

    wb_select #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LINK_REG (LINK_REG)
    ) u_wb_select (
        .i_rt_addr    (bus.rt_addr),
        .i_rd_addr    (bus.rd_addr),
        .i_reg_dst    (bus.RegDst),
        .i_reg_jal    (bus.RegJal),
        .i_data_jal   (bus.DataJal),
        .i_reg_write  (bus.RegWrite),
        .i_mem_to_reg (bus.MemToReg),
        .i_alu_result (bus.alu_result),
        .i_mem_rdata  (bus.mem_rdata),
        .i_pc_plus4   (bus.pc_plus4),
        .o_wb_en      (w_wb_en),
        .o_wb_addr    (w_wb_addr),
        .o_wb_data    (w_wb_data)
    );

    // Commit one write per edge; reset clears the whole array without a clock.
    // w_wb_en already excludes index 0, so r_regs[0] stays zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_en) begin
            r_regs[w_wb_addr] <= w_wb_data;
        end
    end

    // Count committed writes; wraps naturally at 2**CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commit_cnt <= '0;
        end else if (w_wb_en) begin
            r_commit_cnt <= r_commit_cnt + 1'b1;
        end
    end

    // Unbypassed reads from current state; index 0 is hard-wired to zero
    always_comb begin
        bus.rs_data  = (bus.rs_addr  == c_zero_idx) ? '0 : r_regs[bus.rs_addr];
        bus.rt_data  = (bus.rt_addr  == c_zero_idx) ? '0 : r_regs[bus.rt_addr];
        bus.dbg_data = (bus.dbg_addr == c_zero_idx) ? '0 : r_regs[bus.dbg_addr];
    end

    // Expose the writeback decision and counter
    always_comb begin
        bus.wb_en      = w_wb_en;
        bus.wb_addr    = w_wb_addr;
        bus.wb_data    = w_wb_data;
        bus.commit_cnt = r_commit_cnt;
    end

endmodule : reg_file_wb
`default_nettype wire
